ysyx_24100005_lsu: RTL and testbench
====================================

# ysyx_24100005_lsu

Multi-cycle load/store unit between the NPC execute stage and the data-memory port. It replaces the single-cycle DPI memory access path with a handshaked request/response engine. The unit is parametrised in data width (RV32/RV64), and adds alignment checking, a memory-response timeout, byte-lane write strobes and load sign/zero extension. It is the first block of the multi-cycle NPC and sits between the EXU and the memory bus model.

## Interface
- `XLEN`, 32 — data/address width; legal values 32 or 64.
- `TIMEOUT`, 255 — maximum cycles spent in WAIT before an error response; must be ≥ 1.
- `clk` input 1 — clock.
- `rst` input 1 — reset: one clock domain; reset is asynchronous and active-low.
- `req_valid` input 1 — EXU load/store request valid.
- `req_ready` output 1 — LSU accepts a request.
- `req_store` input 1 — 1 = store, 0 = load.
- `req_funct3` input 3 — RISC-V funct3 (b/h/w/d, bu/hu/wu).
- `req_addr` input XLEN — byte address.
- `req_wdata` input XLEN — store data, right-aligned.
- `mem_req_valid` output 1 — bus request valid.
- `mem_req_ready` input 1 — bus accepts the request.
- `mem_we` output 1 — bus write enable.
- `mem_addr` output XLEN — address, aligned down to XLEN/8 bytes.
- `mem_wdata` output XLEN — store data, shifted to its byte lanes.
- `mem_wmask` output XLEN/8 — byte strobes.
- `mem_rsp_valid` input 1 — bus response valid.
- `mem_rsp_ready` output 1 — LSU accepts the bus response.
- `mem_rdata` input XLEN — full-width read data.
- `rsp_valid` output 1 — result valid to EXU/WBU.
- `rsp_ready` input 1 — consumer accepts the result.
- `rsp_rdata` output XLEN — extended load data; 0 for stores.
- `rsp_err` output 1 — misaligned, illegal funct3 or timeout.

## Operation
- FSM states: IDLE → REQ → WAIT → RESP → IDLE.
- IDLE: `req_ready`=1. On `req_valid`, latch store, funct3, addr and wdata.
  - Illegal funct3 → RESP with err=1. Illegal cases: store funct3 ≥ 100; 011 or 110 when XLEN=32; 111.
  - Misaligned access (h: addr[0]≠0; w: addr[1:0]≠0; d: addr[2:0]≠0) → RESP with err=1, no bus access.
  - Otherwise → REQ.
- REQ: `mem_req_valid`=1. Address, data, mask and we are held stable until `mem_req_ready`, then → WAIT.
- Store mask: size-ones shifted left by addr[log2(XLEN/8)-1:0]. Examples: sb@offset 3 → 4'b1000; sh@2 → 4'b1100; sw → 4'b1111.
- Store data: `req_wdata` shifted left by offset×8.
- WAIT: `mem_rsp_ready`=1. On `mem_rsp_valid`:
  - Load: extract the field from `mem_rdata` at the offset, then sign-extend (b/h/w) or zero-extend (bu/hu/wu).
  - Store: rdata = 0.
  - Then → RESP with err=0.
- WAIT timeout: a counter increments each WAIT cycle. When it reaches `TIMEOUT` with no response → RESP with err=1 and rdata=0. A later stray `mem_rsp_valid` in IDLE is ignored (`mem_rsp_ready`=0).
- RESP: `rsp_valid`=1 with data/err stable until `rsp_ready`, then → IDLE.

## Timing
- Reset values of all outputs: `req_ready`=1 (state IDLE); every other output 0; timeout counter 0. Reset mid-transaction returns to IDLE immediately and drops any pending bus request.
- Request-to-response latency (zero-wait bus, both ready high): accept at cycle 0, REQ at cycle 1, WAIT at cycle 2 (response sampled), `rsp_valid` at cycle 3.
- Error paths: `rsp_valid` appears 1 cycle after accept.
- Back-to-back: the earliest next accept is the cycle after the RESP handshake. There is no overlap: one outstanding transaction.
- All outputs are registered or decoded from state plus latched fields only; there is no combinational path from `req_*` to `mem_*`.
- The timeout counter is XLEN-independent, width $clog2(TIMEOUT+1), and is cleared on entry to WAIT.

## Structure
- Package `ysyx_24100005_lsu_pkg` holds:
  - state enum;
  - funct3 constants (LB=000, LH=001, LW=010, LD=011, LBU=100, LHU=101, LWU=110);
  - function `size_bytes(funct3)`.
- Sub-module `ysyx_24100005_lsu_align`: combinational mask/data shift for stores and extract/extend for loads. It is instantiated once, inside the FSM module.

## Test plan
- XLEN=32, sb addr 0x8000_0003, wdata 0x0000_00AB, zero-wait bus → `mem_addr`=0x8000_0000, `mem_wmask`=4'b1000, `mem_wdata`=0xAB00_0000; `rsp_valid` at cycle 3 with err=0.
- lb addr 0x8000_0002, `mem_rdata`=0x00F0_0000 → `rsp_rdata`=0xFFFF_FFF0. Same access with lbu → 0x0000_00F0.
- lw addr 0x8000_0002 → err=1 one cycle after accept; `mem_req_valid` never asserted.
- TIMEOUT=4, bus never responds → `rsp_err`=1 exactly 4 cycles after entering WAIT.
- Bus stalls `mem_req_ready` for 3 cycles and consumer holds `rsp_ready`=0 for 2 cycles → `mem_*` and `rsp_*` remain stable throughout; exactly one transaction completes.
- XLEN=64, ld at 0x...8 with `mem_rdata`=0x8000_0000_0000_0001 → rdata unchanged. Assert `rst` low while in WAIT → all outputs at reset values on the next edge.

Source files
------------

// File: rtl/ysyx_24100005_lsu_pkg.sv
// Shared types, funct3 encodings and size helper for the multi-cycle load/store unit.
package ysyx_24100005_lsu_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_RESP
    } lsu_state_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;

    // Access size in bytes; the low two funct3 bits encode log2(size) for loads and stores alike.
    function automatic logic [3:0] size_bytes(input logic [2:0] funct3);
        case (funct3[1:0])
            2'b00:   size_bytes = 4'd1;
            2'b01:   size_bytes = 4'd2;
            2'b10:   size_bytes = 4'd4;
            default: size_bytes = 4'd8;
        endcase
    endfunction

endpackage

// File: rtl/ysyx_24100005_lsu_if.sv
// Handshake bundles of the LSU: the EXU-facing request/response side and the data-memory bus side.
interface ysyx_24100005_lsu_if #(
    parameter int XLEN = 32
) ();
    logic            req_valid;
    logic            req_ready;
    logic            req_store;
    logic [2:0]      req_funct3;
    logic [XLEN-1:0] req_addr;
    logic [XLEN-1:0] req_wdata;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [XLEN-1:0] rsp_rdata;
    logic            rsp_err;

    modport master (
        output req_valid, req_store, req_funct3, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_store, req_funct3, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

interface ysyx_24100005_lsu_mem_if #(
    parameter int XLEN = 32
) ();
    logic              mem_req_valid;
    logic              mem_req_ready;
    logic              mem_we;
    logic [XLEN-1:0]   mem_addr;
    logic [XLEN-1:0]   mem_wdata;
    logic [XLEN/8-1:0] mem_wmask;
    logic              mem_rsp_valid;
    logic              mem_rsp_ready;
    logic [XLEN-1:0]   mem_rdata;

    modport master (
        output mem_req_valid, mem_we, mem_addr, mem_wdata, mem_wmask, mem_rsp_ready,
        input  mem_req_ready, mem_rsp_valid, mem_rdata
    );

    modport slave (
        input  mem_req_valid, mem_we, mem_addr, mem_wdata, mem_wmask, mem_rsp_ready,
        output mem_req_ready, mem_rsp_valid, mem_rdata
    );
endinterface

// File: rtl/ysyx_24100005_lsu_align.sv
// Byte-lane steering: store mask/data placement and load field extraction with sign/zero extension.
module ysyx_24100005_lsu_align
    import ysyx_24100005_lsu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]                 funct3,
    input  logic [$clog2(XLEN/8)-1:0]  offset,
    input  logic [XLEN-1:0]            st_data,
    input  logic [XLEN-1:0]            ld_data,
    output logic [XLEN/8-1:0]          wmask,
    output logic [XLEN-1:0]            wdata,
    output logic [XLEN-1:0]            rdata
);
    localparam int NB = XLEN / 8;

    logic [NB-1:0]   base_mask;
    logic [XLEN-1:0] shifted;

    always_comb begin
        base_mask = '0;
        for (int i = 0; i < NB; i++) begin
            base_mask[i] = (i < int'(size_bytes(funct3)));
        end
        wmask   = base_mask << offset;
        wdata   = st_data << {offset, 3'b000};
        shifted = ld_data >> {offset, 3'b000};

        // Signed casts to the full width give the sign extension for b/h/w.
        case (funct3)
            F3_LB:   rdata = XLEN'($signed(shifted[7:0]));
            F3_LH:   rdata = XLEN'($signed(shifted[15:0]));
            F3_LW:   rdata = XLEN'($signed(shifted[31:0]));
            F3_LBU:  rdata = XLEN'(shifted[7:0]);
            F3_LHU:  rdata = XLEN'(shifted[15:0]);
            F3_LWU:  rdata = XLEN'(shifted[31:0]);
            F3_LD:   rdata = shifted;
            default: rdata = '0;
        endcase
    end

endmodule

// File: rtl/ysyx_24100005_lsu.sv
// Multi-cycle load/store engine: accepts one EXU request, runs one bus transaction, returns an extended result.
module ysyx_24100005_lsu
    import ysyx_24100005_lsu_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 255
) (
    input logic                    clk,
    input logic                    rst,
    ysyx_24100005_lsu_if.slave     core,
    ysyx_24100005_lsu_mem_if.master mem
);
    localparam int NB   = XLEN / 8;
    localparam int OFFW = $clog2(NB);
    localparam int CW   = $clog2(TIMEOUT + 1);

    lsu_state_e      state;
    logic            lat_store;
    logic [2:0]      lat_funct3;
    logic [XLEN-1:0] lat_addr;
    logic [XLEN-1:0] lat_wdata;
    logic [CW-1:0]   wait_cnt;

    logic            req_ready_q;
    logic            mem_req_valid_q;
    logic            mem_we_q;
    logic            mem_rsp_ready_q;
    logic            rsp_valid_q;
    logic            rsp_err_q;
    logic [XLEN-1:0] rsp_rdata_q;

    logic [NB-1:0]   al_wmask;
    logic [XLEN-1:0] al_wdata;
    logic [XLEN-1:0] al_rdata;
    logic            req_illegal;
    logic            req_misaligned;

    always_comb begin
        req_illegal = (core.req_funct3 == 3'b111)
                   || (core.req_store && core.req_funct3[2])
                   || ((XLEN == 32) && (core.req_funct3 == F3_LD || core.req_funct3 == F3_LWU));
        case (core.req_funct3[1:0])
            2'b01:   req_misaligned = core.req_addr[0];
            2'b10:   req_misaligned = |core.req_addr[1:0];
            2'b11:   req_misaligned = |core.req_addr[2:0];
            default: req_misaligned = 1'b0;
        endcase
    end

    ysyx_24100005_lsu_align #(.XLEN(XLEN)) u_align (
        .funct3  (lat_funct3),
        .offset  (lat_addr[OFFW-1:0]),
        .st_data (lat_wdata),
        .ld_data (mem.mem_rdata),
        .wmask   (al_wmask),
        .wdata   (al_wdata),
        .rdata   (al_rdata)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state           <= S_IDLE;
            lat_store       <= 1'b0;
            lat_funct3      <= 3'b000;
            lat_addr        <= '0;
            lat_wdata       <= '0;
            wait_cnt        <= '0;
            req_ready_q     <= 1'b1;
            mem_req_valid_q <= 1'b0;
            mem_we_q        <= 1'b0;
            mem_rsp_ready_q <= 1'b0;
            rsp_valid_q     <= 1'b0;
            rsp_err_q       <= 1'b0;
            rsp_rdata_q     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (core.req_valid) begin
                        lat_store   <= core.req_store;
                        lat_funct3  <= core.req_funct3;
                        lat_addr    <= core.req_addr;
                        lat_wdata   <= core.req_wdata;
                        req_ready_q <= 1'b0;
                        // Bad requests never touch the bus.
                        if (req_illegal || req_misaligned) begin
                            state       <= S_RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b1;
                            rsp_rdata_q <= '0;
                        end else begin
                            state           <= S_REQ;
                            mem_req_valid_q <= 1'b1;
                            mem_we_q        <= core.req_store;
                        end
                    end
                end
                S_REQ: begin
                    if (mem.mem_req_ready) begin
                        state           <= S_WAIT;
                        mem_req_valid_q <= 1'b0;
                        mem_we_q        <= 1'b0;
                        mem_rsp_ready_q <= 1'b1;
                        wait_cnt        <= '0;
                    end
                end
                S_WAIT: begin
                    if (mem.mem_rsp_valid) begin
                        state           <= S_RESP;
                        mem_rsp_ready_q <= 1'b0;
                        rsp_valid_q     <= 1'b1;
                        rsp_err_q       <= 1'b0;
                        rsp_rdata_q     <= lat_store ? '0 : al_rdata;
                    end else if (wait_cnt == CW'(TIMEOUT - 1)) begin
                        state           <= S_RESP;
                        mem_rsp_ready_q <= 1'b0;
                        rsp_valid_q     <= 1'b1;
                        rsp_err_q       <= 1'b1;
                        rsp_rdata_q     <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                S_RESP: begin
                    if (core.rsp_ready) begin
                        state       <= S_IDLE;
                        rsp_valid_q <= 1'b0;
                        rsp_err_q   <= 1'b0;
                        rsp_rdata_q <= '0;
                        req_ready_q <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Bus payload is decoded from the latched request and forced to zero outside REQ.
    assign mem.mem_req_valid = mem_req_valid_q;
    assign mem.mem_we        = mem_we_q;
    assign mem.mem_addr      = mem_req_valid_q ? (lat_addr & ~XLEN'(NB - 1)) : '0;
    assign mem.mem_wdata     = (mem_req_valid_q && mem_we_q) ? al_wdata : '0;
    assign mem.mem_wmask     = (mem_req_valid_q && mem_we_q) ? al_wmask : '0;
    assign mem.mem_rsp_ready = mem_rsp_ready_q;

    assign core.req_ready = req_ready_q;
    assign core.rsp_valid = rsp_valid_q;
    assign core.rsp_err   = rsp_err_q;
    assign core.rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_ysyx_24100005_lsu.sv
// Drives an RV32 and an RV64 LSU (one at a time via sel) and compares against an arithmetic reference model.
module tb_ysyx_24100005_lsu;
    import ysyx_24100005_lsu_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        sel;
    logic        req_valid;
    logic        req_store;
    logic [2:0]  req_funct3;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic        rsp_ready;
    logic        mem_req_ready;
    logic        mem_rsp_valid;
    logic [63:0] mem_rdata;

    logic        o_req_ready;
    logic        o_mem_req_valid;
    logic        o_mem_we;
    logic [63:0] o_mem_addr;
    logic [63:0] o_mem_wdata;
    logic [7:0]  o_mem_wmask;
    logic        o_mem_rsp_ready;
    logic        o_rsp_valid;
    logic        o_rsp_err;
    logic [63:0] o_rsp_rdata;

    int total = 0;
    int bad   = 0;

    ysyx_24100005_lsu_if     #(.XLEN(32)) core32 ();
    ysyx_24100005_lsu_mem_if #(.XLEN(32)) mem32 ();
    ysyx_24100005_lsu_if     #(.XLEN(64)) core64 ();
    ysyx_24100005_lsu_mem_if #(.XLEN(64)) mem64 ();

    ysyx_24100005_lsu #(.XLEN(32), .TIMEOUT(4)) u_dut32 (
        .clk  (clk),
        .rst  (rst),
        .core (core32),
        .mem  (mem32)
    );

    ysyx_24100005_lsu #(.XLEN(64), .TIMEOUT(4)) u_dut64 (
        .clk  (clk),
        .rst  (rst),
        .core (core64),
        .mem  (mem64)
    );

    assign core32.req_valid  = req_valid & ~sel;
    assign core32.req_store  = req_store;
    assign core32.req_funct3 = req_funct3;
    assign core32.req_addr   = req_addr[31:0];
    assign core32.req_wdata  = req_wdata[31:0];
    assign core32.rsp_ready  = rsp_ready & ~sel;
    assign mem32.mem_req_ready = mem_req_ready;
    assign mem32.mem_rsp_valid = mem_rsp_valid & ~sel;
    assign mem32.mem_rdata     = mem_rdata[31:0];

    assign core64.req_valid  = req_valid & sel;
    assign core64.req_store  = req_store;
    assign core64.req_funct3 = req_funct3;
    assign core64.req_addr   = req_addr;
    assign core64.req_wdata  = req_wdata;
    assign core64.rsp_ready  = rsp_ready & sel;
    assign mem64.mem_req_ready = mem_req_ready;
    assign mem64.mem_rsp_valid = mem_rsp_valid & sel;
    assign mem64.mem_rdata     = mem_rdata;

    assign o_req_ready     = sel ? core64.req_ready     : core32.req_ready;
    assign o_mem_req_valid = sel ? mem64.mem_req_valid  : mem32.mem_req_valid;
    assign o_mem_we        = sel ? mem64.mem_we         : mem32.mem_we;
    assign o_mem_addr      = sel ? mem64.mem_addr       : {32'd0, mem32.mem_addr};
    assign o_mem_wdata     = sel ? mem64.mem_wdata      : {32'd0, mem32.mem_wdata};
    assign o_mem_wmask     = sel ? mem64.mem_wmask      : {4'd0, mem32.mem_wmask};
    assign o_mem_rsp_ready = sel ? mem64.mem_rsp_ready  : mem32.mem_rsp_ready;
    assign o_rsp_valid     = sel ? core64.rsp_valid     : core32.rsp_valid;
    assign o_rsp_err       = sel ? core64.rsp_err       : core32.rsp_err;
    assign o_rsp_rdata     = sel ? core64.rsp_rdata     : {32'd0, core32.rsp_rdata};

    typedef struct packed {
        logic        err;
        logic [63:0] addr;
        logic [7:0]  wmask;
        logic [63:0] wdata;
        logic [63:0] rdata;
    } exp_t;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Expected outcome of one access, derived from sizes, offsets and masks with plain arithmetic.
    function automatic exp_t refModel(input int xlen, input logic store, input logic [2:0] f3,
                                      input logic [63:0] addr, input logic [63:0] wdata,
                                      input logic [63:0] rdata);
        exp_t        e;
        int          size;
        int          nb;
        int          off;
        logic [63:0] xmask;
        logic [63:0] fmask;
        logic [63:0] field;
        e     = '0;
        size  = 1 << f3[1:0];
        nb    = xlen / 8;
        xmask = (xlen == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
        off   = int'(addr % 64'(nb));
        e.err = (f3 == 3'd7) || (store && f3 >= 3'd4) || (xlen == 32 && (f3 == 3'd3 || f3 == 3'd6))
             || ((addr % 64'(size)) != 64'd0);
        e.addr  = (addr - 64'(off)) & xmask;
        e.wmask = 8'(((1 << size) - 1) << off);
        e.wdata = (wdata << (8 * off)) & xmask;
        fmask = (size == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (8 * size)) - 64'd1);
        field = (rdata >> (8 * off)) & fmask;
        if (!f3[2] && size < 8 && field[8 * size - 1]) field = field | ~fmask;
        e.rdata = (store || e.err) ? 64'd0 : (field & xmask);
        return e;
    endfunction

    task automatic checkReset(input string tag);
        checkOutput({tag, "_req_ready"},     o_req_ready, 1);
        checkOutput({tag, "_mem_req_valid"}, o_mem_req_valid, 0);
        checkOutput({tag, "_mem_we"},        o_mem_we, 0);
        checkOutput({tag, "_mem_addr"},      o_mem_addr, 0);
        checkOutput({tag, "_mem_wdata"},     o_mem_wdata, 0);
        checkOutput({tag, "_mem_wmask"},     o_mem_wmask, 0);
        checkOutput({tag, "_mem_rsp_ready"}, o_mem_rsp_ready, 0);
        checkOutput({tag, "_rsp_valid"},     o_rsp_valid, 0);
        checkOutput({tag, "_rsp_err"},       o_rsp_err, 0);
        checkOutput({tag, "_rsp_rdata"},     o_rsp_rdata, 0);
    endtask

    // One full transaction with configurable bus and consumer back-pressure; all sampling at posedge+1.
    task automatic applyStimulus(input logic st, input logic [2:0] f3, input logic [63:0] addr,
                                 input logic [63:0] wdata, input logic [63:0] rdata,
                                 input int req_stall, input int rsp_delay, input int out_stall);
        exp_t        e;
        logic [63:0] xm;
        xm = sel ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
        e  = refModel(sel ? 64 : 32, st, f3, addr & xm, wdata & xm, rdata & xm);

        checkOutput("idle_ready", o_req_ready, 1);
        req_valid  = 1'b1;
        req_store  = st;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        @(posedge clk); #1;
        req_valid  = 1'b0;
        req_addr   = {$urandom, $urandom};
        req_wdata  = {$urandom, $urandom};
        req_funct3 = 3'($urandom_range(0, 7));

        if (e.err) begin
            checkOutput("err_rsp_valid", o_rsp_valid, 1);
            checkOutput("err_no_bus", o_mem_req_valid, 0);
        end else begin
            for (int i = 0; i <= req_stall; i++) begin
                checkOutput("req_valid", o_mem_req_valid, 1);
                checkOutput("req_addr", o_mem_addr, e.addr);
                checkOutput("req_we", o_mem_we, 64'(st));
                if (st) begin
                    checkOutput("req_wmask", o_mem_wmask, e.wmask);
                    checkOutput("req_wdata", o_mem_wdata, e.wdata);
                end
                checkOutput("req_no_rsp", o_rsp_valid, 0);
                mem_req_ready = (i == req_stall);
                @(posedge clk); #1;
            end
            mem_req_ready = 1'b0;
            for (int i = 0; i <= rsp_delay; i++) begin
                checkOutput("wait_rsp_ready", o_mem_rsp_ready, 1);
                checkOutput("wait_no_req", o_mem_req_valid, 0);
                checkOutput("wait_no_rsp", o_rsp_valid, 0);
                mem_rsp_valid = (i == rsp_delay);
                mem_rdata     = (i == rsp_delay) ? rdata : {$urandom, $urandom};
                @(posedge clk); #1;
            end
            mem_rsp_valid = 1'b0;
            mem_rdata     = {$urandom, $urandom};
        end

        for (int i = 0; i <= out_stall; i++) begin
            checkOutput("rsp_valid", o_rsp_valid, 1);
            checkOutput("rsp_err", o_rsp_err, 64'(e.err));
            checkOutput("rsp_rdata", o_rsp_rdata, e.rdata);
            checkOutput("rsp_busy", o_req_ready, 0);
            checkOutput("rsp_no_req", o_mem_req_valid, 0);
            rsp_ready = (i == out_stall);
            @(posedge clk); #1;
        end
        rsp_ready = 1'b0;
        checkOutput("rsp_done", o_rsp_valid, 0);
    endtask

    // Bus accepts a load but never answers; then a stray response arrives while idle.
    task automatic runTimeout();
        int cycles;
        req_valid  = 1'b1;
        req_store  = 1'b0;
        req_funct3 = F3_LW;
        req_addr   = 64'h0000_0000_8000_0004;
        @(posedge clk); #1;
        req_valid     = 1'b0;
        mem_req_ready = 1'b1;
        @(posedge clk); #1;
        mem_req_ready = 1'b0;
        cycles = 0;
        while (o_rsp_valid !== 1'b1 && cycles < 20) begin
            @(posedge clk); #1;
            cycles++;
        end
        checkOutput("to_cycles", 64'(cycles), 4);
        checkOutput("to_err", o_rsp_err, 1);
        checkOutput("to_rdata", o_rsp_rdata, 0);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready     = 1'b0;
        mem_rsp_valid = 1'b1;
        mem_rdata     = {$urandom, $urandom};
        checkOutput("stray_ready", o_mem_rsp_ready, 0);
        @(posedge clk); #1;
        mem_rsp_valid = 1'b0;
        checkOutput("stray_ignored", o_rsp_valid, 0);
        checkOutput("stray_idle", o_req_ready, 1);
    endtask

    task automatic runResetInWait();
        req_valid  = 1'b1;
        req_store  = 1'b0;
        req_funct3 = F3_LD;
        req_addr   = 64'h0000_0000_8000_0010;
        @(posedge clk); #1;
        req_valid     = 1'b0;
        mem_req_ready = 1'b1;
        @(posedge clk); #1;
        mem_req_ready = 1'b0;
        checkOutput("rstw_in_wait", o_mem_rsp_ready, 1);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        checkReset("rstw");
        rst = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        rst           = 1'b0;
        sel           = 1'b0;
        req_valid     = 1'b0;
        req_store     = 1'b0;
        req_funct3    = 3'b000;
        req_addr      = '0;
        req_wdata     = '0;
        rsp_ready     = 1'b0;
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rdata     = '0;

        repeat (3) @(posedge clk);
        #1;
        checkReset("reset32");
        sel = 1'b1;
        #1;
        checkReset("reset64");
        sel = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;

        $display("[TB] directed RV32 accesses");
        applyStimulus(1'b1, F3_LB,  64'h8000_0003, 64'h0000_00AB, 64'd0, 0, 0, 0);
        applyStimulus(1'b0, F3_LB,  64'h8000_0002, 64'd0, 64'h00F0_0000, 0, 0, 0);
        applyStimulus(1'b0, F3_LBU, 64'h8000_0002, 64'd0, 64'h00F0_0000, 0, 0, 0);
        applyStimulus(1'b0, F3_LW,  64'h8000_0002, 64'd0, 64'h1234_5678, 0, 0, 0);
        applyStimulus(1'b1, F3_LH,  64'h8000_0002, 64'h0000_BEEF, 64'd0, 3, 1, 2);
        applyStimulus(1'b0, F3_LHU, 64'h8000_0002, 64'd0, 64'h8001_0000, 1, 2, 0);
        applyStimulus(1'b0, F3_LD,  64'h8000_0000, 64'd0, 64'd0, 0, 0, 0);
        applyStimulus(1'b1, F3_LBU, 64'h8000_0000, 64'h55, 64'd0, 0, 0, 0);
        runTimeout();

        sel = 1'b1;
        #1;
        $display("[TB] directed RV64 accesses");
        applyStimulus(1'b0, F3_LD,  64'h0000_0000_8000_0008, 64'd0, 64'h8000_0000_0000_0001, 0, 0, 0);
        applyStimulus(1'b0, F3_LWU, 64'h0000_0000_8000_0004, 64'd0, 64'h8765_4321_0000_0000, 0, 0, 0);
        applyStimulus(1'b1, F3_LD,  64'h0000_0000_8000_0004, 64'h1, 64'd0, 0, 0, 0);
        applyStimulus(1'b1, F3_LW,  64'h0000_0000_8000_0004, 64'hCAFE_F00D, 64'd0, 2, 0, 1);

        $display("[TB] random accesses");
        for (int n = 0; n < 80; n++) begin
            logic        st;
            logic [2:0]  f3;
            logic [31:0] lo;
            int          off;
            sel = n[0];
            #1;
            st  = 1'($urandom_range(0, 1));
            f3  = 3'($urandom_range(0, 7));
            off = $urandom_range(0, 7);
            if ($urandom_range(0, 3) != 0) off = off & ~((1 << f3[1:0]) - 1);
            lo  = 32'h8000_0000 | 32'(off) | (32'($urandom_range(0, 3)) << 3);
            applyStimulus(st, f3, {$urandom, lo}, {$urandom, $urandom}, {$urandom, $urandom},
                          $urandom_range(0, 3), $urandom_range(0, 2), $urandom_range(0, 2));
        end

        sel = 1'b1;
        #1;
        runTimeout();
        runResetInWait();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
